ysyx_22050019_lsu_fsm: RTL and testbench
========================================

YSYX_22050019_LSU_FSM -- requirements
Module: ysyx_22050019_lsu_fsm

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 64, address width.
- DATA_W, 64, data and register width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-high (asserted = 1).
- req_valid_i  in  1  EXU presents a memory operation.
- req_ready_o  out  1  LSU can accept a request.
- load_i  in  1  operation is a load.
- store_i  in  1  operation is a store.
- funct3_i  in  3  size/sign: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  DATA_W  store data, LSB-justified.
- rd_i  in  5  load destination register.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_addr_o  out  ADDR_W  address, bits [2:0] forced to 0.
- mem_wen_o  out  1  request is a write.
- mem_wdata_o  out  DATA_W  store data shifted to its lane.
- mem_wstrb_o  out  8  byte enables.
- mem_resp_valid_i  in  1  response valid.
- mem_resp_ready_o  out  1  LSU accepts the response.
- mem_rdata_i  in  DATA_W  read data, 8-byte aligned.
- mem_resp_err_i  in  1  bus error.
- reg_we_lsu_o  out  1  write-back enable to MEM_WB.
- reg_waddr_lsu_o  out  5  write-back register index.
- reg_wdata_lsu_o  out  DATA_W  extended load result.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse: misaligned access or bus error.
- stall_o  out  1  pipeline stall request.

Function
REQ-003 FSM states SHALL be IDLE, REQ, RESP, DONE.
REQ-004 req_ready_o SHALL be 1 only in IDLE.
REQ-005 A request SHALL be accepted on a clock edge with req_valid_i & req_ready_o & (load_i | store_i).
REQ-006 On acceptance, addr, data, funct3, rd and op SHALL be captured; load_i SHALL take priority when load_i and store_i are both set.
REQ-007 On acceptance of a naturally misaligned request (h: addr[0]≠0; w: addr[1:0]≠0; d: addr[2:0]≠0), the FSM SHALL go to DONE without a memory access and pulse err_o.
REQ-008 On acceptance of an aligned request, the FSM SHALL go IDLE→REQ.
REQ-009 In REQ, mem_req_valid_o SHALL be 1 and all mem_* request fields SHALL stay stable until mem_req_ready_i; the transition REQ→RESP SHALL occur on that handshake edge.
REQ-010 In RESP, mem_resp_ready_o SHALL be 1; the transition RESP→DONE SHALL occur on mem_resp_valid_i.
REQ-011 A response arriving in the same cycle as the request handshake SHALL be ignored; responses are counted only in RESP.
REQ-012 In DONE, done_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-013 In DONE, reg_we_lsu_o SHALL be 1 only for a load with no error and rd≠0.
REQ-014 mem_resp_err_i SHALL produce err_o in DONE, and the response data SHALL be discarded.
REQ-015 Store encoding: off=addr[2:0]; mem_wdata_o = wdata_i << 8*off; mem_wstrb_o = (0x01/0x03/0x0F/0xFF for b/h/w/d) << off.
REQ-016 Load encoding: rdata >> 8*off, truncated to size, then sign-extended (lb/lh/lw) or zero-extended (lbu/lhu/lwu/ld) to 64 bits.
REQ-017 stall_o SHALL equal (state≠IDLE) | (req_valid_i & (load_i | store_i) & state==IDLE).
REQ-018 Minimum latency SHALL be: accept at edge N, mem_req_valid_o in cycle N+1, response in N+2, done_o in N+3.
REQ-019 reg_wdata_lsu_o and reg_waddr_lsu_o SHALL be 0 whenever reg_we_lsu_o is 0.

Reset
REQ-020 Asserting rst_n SHALL immediately force IDLE and drive every output to 0, except req_ready_o, which SHALL be 1 while reset is asserted.
REQ-021 Reset mid-transaction SHALL abandon the transaction with no done_o; the memory side is reset from the same signal.

Structure
REQ-022 Package ysyx_22050019_lsu_pkg SHALL hold the state enum, the funct3 size/sign constants, and ADDR_W/DATA_W defaults.
REQ-023 Combinational store-lane, strobe and load-extract logic SHALL live in sub-module ysyx_22050019_lsu_align; the FSM and registers SHALL live in the top.

Verification
REQ-024 lb at addr 0x80000003, rdata 0x00000000_80FF0000, rd=5, zero-wait memory -> done at N+3, reg_we=1, waddr=5, wdata=0xFFFFFFFFFFFFFF80.
REQ-025 sh at 0x80000006, wdata 0xABCD -> mem_addr 0x80000000, wstrb 0xC0, wdata 0xABCD000000000000, wen=1, reg_we=0, done pulse.
REQ-026 lw at 0x80000002 -> no mem_req_valid_o, err_o and done_o at N+1 only, reg_we=0.
REQ-027 ld with mem_req_ready_i low 3 cycles, response 2 cycles later -> request fields stable throughout, stall_o high continuously, done exactly once.
REQ-028 rst_n pulsed while in RESP -> outputs 0 asynchronously, IDLE afterwards, no done_o; next lbu at 0x0 with rdata 0x80 -> wdata 0x80.
REQ-029 Load with rd=0 and bus error on a separate load -> reg_we=0 in both cases; err_o=1 only for the error case.

Source files
------------

// File: rtl/ysyx_22050019_lsu_pkg.sv
// ysyx_22050019_lsu_pkg: shared types, size/sign constants and alignment helpers for the LSU
package ysyx_22050019_lsu_pkg;

    localparam int LSU_ADDR_W = 64;
    localparam int LSU_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_e;

    // funct3[1:0] encodes access size, funct3[2] selects zero-extension
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;
    localparam int F3_UNS_BIT = 2;

    function automatic logic [7:0] size_strb(input logic [1:0] sz);
        return (sz == SZ_B) ? 8'h01 : (sz == SZ_H) ? 8'h03 : (sz == SZ_W) ? 8'h0F : 8'hFF;
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
        logic [2:0] m;
        m = (sz == SZ_B) ? 3'b000 : (sz == SZ_H) ? 3'b001 : (sz == SZ_W) ? 3'b011 : 3'b111;
        return |(off & m);
    endfunction

endpackage

// File: rtl/ysyx_22050019_lsu_align.sv
// ysyx_22050019_lsu_align: store lane/strobe placement and load extract/extension
module ysyx_22050019_lsu_align
    import ysyx_22050019_lsu_pkg::*;
#(
    parameter int DATA_W = LSU_DATA_W
) (
    input  logic [2:0]        funct3_i,
    input  logic [2:0]        off_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [7:0]        wstrb_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [1:0]        sz;
    logic              sx;
    logic [5:0]        sh;
    logic [DATA_W-1:0] rs;

    // shift stores into their byte lane and right-justify loads before extension
    always_comb begin
        sz      = funct3_i[1:0];
        sx      = ~funct3_i[F3_UNS_BIT];
        sh      = {off_i, 3'b000};
        wdata_o = wdata_i << sh;
        wstrb_o = size_strb(sz) << off_i;
        rs      = rdata_i >> sh;
        rdata_o = (sz == SZ_B) ? {{(DATA_W-8){sx & rs[7]}}, rs[7:0]} :
                  (sz == SZ_H) ? {{(DATA_W-16){sx & rs[15]}}, rs[15:0]} :
                  (sz == SZ_W) ? {{(DATA_W-32){sx & rs[31]}}, rs[31:0]} : rs;
    end

endmodule

// File: rtl/ysyx_22050019_lsu_fsm.sv
// ysyx_22050019_lsu_fsm: load/store unit FSM bridging EXU requests to a valid/ready memory port
module ysyx_22050019_lsu_fsm
    import ysyx_22050019_lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              load_i,
    input  logic              store_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [4:0]        rd_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wen_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [7:0]        mem_wstrb_o,
    input  logic              mem_resp_valid_i,
    output logic              mem_resp_ready_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_resp_err_i,
    output logic              reg_we_lsu_o,
    output logic [4:0]        reg_waddr_lsu_o,
    output logic [DATA_W-1:0] reg_wdata_lsu_o,
    output logic              done_o,
    output logic              err_o,
    output logic              stall_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic              load_q, load_d;
    logic              err_q, err_d;
    logic              accept, in_req;
    logic [DATA_W-1:0] lane_wdata, load_data;
    logic [7:0]        lane_strb;

    ysyx_22050019_lsu_align #(.DATA_W(DATA_W)) u_align (
        .funct3_i (f3_q),
        .off_i    (addr_q[2:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (rdata_q),
        .wdata_o  (lane_wdata),
        .wstrb_o  (lane_strb),
        .rdata_o  (load_data)
    );

    assign accept = req_valid_i & req_ready_o & (load_i | store_i);

    // next state; request fields are captured on acceptance, read data on the response
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        load_d  = load_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (accept) begin
                addr_d  = addr_i;
                wdata_d = wdata_i;
                f3_d    = funct3_i;
                rd_d    = rd_i;
                load_d  = load_i;
                rdata_d = '0;
                err_d   = misaligned(funct3_i[1:0], addr_i[2:0]);
                state_d = err_d ? DONE : REQ;
            end
            REQ: state_d = mem_req_ready_i ? RESP : REQ;
            RESP: if (mem_resp_valid_i) begin
                state_d = DONE;
                err_d   = mem_resp_err_i;
                rdata_d = mem_resp_err_i ? '0 : mem_rdata_i;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and transaction registers, cleared asynchronously so a reset abandons any transaction
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    assign in_req           = state_q == REQ;
    assign req_ready_o      = state_q == IDLE;
    assign stall_o          = ~rst_n & (~req_ready_o | (req_valid_i & (load_i | store_i)));
    assign mem_req_valid_o  = in_req;
    assign mem_addr_o       = in_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    assign mem_wen_o        = in_req & ~load_q;
    assign mem_wdata_o      = mem_wen_o ? lane_wdata : '0;
    assign mem_wstrb_o      = mem_wen_o ? lane_strb : 8'h00;
    assign mem_resp_ready_o = state_q == RESP;
    assign done_o           = state_q == DONE;
    assign err_o            = done_o & err_q;
    assign reg_we_lsu_o     = done_o & load_q & ~err_q & (rd_q != 5'd0);
    assign reg_waddr_lsu_o  = reg_we_lsu_o ? rd_q : 5'd0;
    assign reg_wdata_lsu_o  = reg_we_lsu_o ? load_data : '0;

endmodule

// File: tb/tb_ysyx_22050019_lsu_fsm.sv
// tb_ysyx_22050019_lsu_fsm: transaction-level reference checked against the LSU every cycle
module tb_ysyx_22050019_lsu_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i, req_ready_o, load_i, store_i;
    logic [2:0]  funct3_i;
    logic [63:0] addr_i, wdata_i;
    logic [4:0]  rd_i;
    logic        mem_req_valid_o, mem_req_ready_i, mem_wen_o;
    logic [63:0] mem_addr_o, mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic        mem_resp_valid_i, mem_resp_ready_o, mem_resp_err_i;
    logic [63:0] mem_rdata_i;
    logic        reg_we_lsu_o, done_o, err_o, stall_o;
    logic [4:0]  reg_waddr_lsu_o;
    logic [63:0] reg_wdata_lsu_o;

    logic        x_ready, x_mreq, x_wen, x_rresp, x_we, x_done, x_err, x_stall;
    logic [63:0] x_addr, x_mwdata, x_wdata;
    logic [7:0]  x_strb;
    logic [4:0]  x_waddr;

    int n_cmp = 0, n_bad = 0, cyc = 0, done_cnt = 0, req_cnt = 0, d_cyc = 0, r_cyc = 0;
    logic [63:0] d_wdata, r_addr, r_wdata;
    logic [4:0]  d_waddr;
    logic        d_we, d_err, r_wen;
    logic [7:0]  r_strb;

    ysyx_22050019_lsu_fsm dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .load_i(load_i), .store_i(store_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o),
        .mem_rdata_i(mem_rdata_i), .mem_resp_err_i(mem_resp_err_i),
        .reg_we_lsu_o(reg_we_lsu_o), .reg_waddr_lsu_o(reg_waddr_lsu_o),
        .reg_wdata_lsu_o(reg_wdata_lsu_o),
        .done_o(done_o), .err_o(err_o), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] strb(input int n, input logic [2:0] off);
        logic [7:0] s;
        for (int i = 0; i < 8; i++) s[i] = (i >= int'(off)) && (i < int'(off) + n);
        return s;
    endfunction

    function automatic logic [63:0] ext(input logic [2:0] f3, input logic [2:0] off, input logic [63:0] d);
        int n;
        logic [63:0] v, m;
        n = 1 << f3[1:0];
        v = d >> (8 * int'(off));
        if (n == 8) return v;
        m = (64'd1 << (8 * n)) - 64'd1;
        v = v & m;
        if (!f3[2] && v[8*n-1]) v = v | ~m;
        return v;
    endfunction

    function automatic void x_idle();
        x_ready = 1'b1; x_mreq = 1'b0; x_wen = 1'b0; x_rresp = 1'b0; x_we = 1'b0;
        x_done = 1'b0; x_err = 1'b0; x_stall = 1'b0;
        x_addr = '0; x_mwdata = '0; x_wdata = '0; x_strb = '0; x_waddr = '0;
    endfunction

    function automatic void rnd_mem();
        mem_req_ready_i  = 1'($urandom_range(0, 1));
        mem_resp_valid_i = 1'($urandom_range(0, 1));
        mem_rdata_i      = {$urandom, $urandom};
        mem_resp_err_i   = 1'($urandom_range(0, 1));
    endfunction

    function automatic void rnd_req();
        req_valid_i = 1'($urandom_range(0, 1));
        load_i      = 1'($urandom_range(0, 1));
        store_i     = 1'($urandom_range(0, 1));
        funct3_i    = 3'($urandom_range(0, 7));
        addr_i      = {$urandom, $urandom};
        wdata_i     = {$urandom, $urandom};
        rd_i        = 5'($urandom_range(0, 31));
    endfunction

    // every cycle, away from the active edge, compare all outputs with the reference
    always @(negedge clk) begin
        check("req_ready", req_ready_o, x_ready);
        check("mem_req_valid", mem_req_valid_o, x_mreq);
        check("mem_addr", mem_addr_o, x_addr);
        check("mem_wen", mem_wen_o, x_wen);
        check("mem_wdata", mem_wdata_o, x_mwdata);
        check("mem_wstrb", mem_wstrb_o, x_strb);
        check("mem_resp_ready", mem_resp_ready_o, x_rresp);
        check("reg_we", reg_we_lsu_o, x_we);
        check("reg_waddr", reg_waddr_lsu_o, x_waddr);
        check("reg_wdata", reg_wdata_lsu_o, x_wdata);
        check("done", done_o, x_done);
        check("err", err_o, x_err);
        check("stall", stall_o, x_stall);
        cyc <= cyc + 1;
        if (done_o) begin
            done_cnt <= done_cnt + 1;
            d_cyc <= cyc;
            d_we <= reg_we_lsu_o; d_waddr <= reg_waddr_lsu_o; d_wdata <= reg_wdata_lsu_o; d_err <= err_o;
        end
        if (mem_req_valid_o) begin
            req_cnt <= req_cnt + 1;
            r_cyc <= cyc;
            r_addr <= mem_addr_o; r_wdata <= mem_wdata_o; r_strb <= mem_wstrb_o; r_wen <= mem_wen_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap(input int k);
        for (int i = 0; i < k; i++) begin
            rnd_mem();
            req_valid_i = 1'($urandom_range(0, 1)); load_i = 1'b0; store_i = 1'b0;
            x_idle();
            tick();
        end
        req_valid_i = 1'b0;
    endtask

    // one full transaction: rw cycles of mem_req_ready low, vw cycles of response delay
    task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input logic [4:0] rd, input int rw, input int vw,
                           input logic [63:0] rdat, input logic berr);
        int n;
        logic [2:0] off;
        logic we;
        n = 1 << f3[1:0];
        off = a[2:0];
        rnd_mem();
        req_valid_i = 1'b1; load_i = ld; store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd; rd_i = rd;
        x_idle(); x_stall = 1'b1;
        tick();
        x_idle(); x_ready = 1'b0; x_stall = 1'b1;
        if (int'(off) % n != 0) begin
            rnd_req(); rnd_mem();
            x_done = 1'b1; x_err = 1'b1;
            tick();
        end else begin
            for (int i = 0; i <= rw; i++) begin
                rnd_req(); rnd_mem();
                mem_req_ready_i = (i == rw);
                x_mreq = 1'b1; x_addr = {a[63:3], 3'b000}; x_wen = !ld;
                x_mwdata = ld ? 64'd0 : (wd << (8 * int'(off)));
                x_strb = ld ? 8'd0 : strb(n, off);
                tick();
            end
            x_mreq = 1'b0; x_addr = '0; x_wen = 1'b0; x_mwdata = '0; x_strb = '0; x_rresp = 1'b1;
            for (int i = 0; i <= vw; i++) begin
                rnd_req(); rnd_mem();
                mem_resp_valid_i = (i == vw);
                if (i == vw) begin
                    mem_rdata_i = rdat; mem_resp_err_i = berr;
                end
                tick();
            end
            rnd_req(); rnd_mem();
            we = ld & !berr & (rd != 5'd0);
            x_rresp = 1'b0; x_done = 1'b1; x_err = berr; x_we = we;
            x_waddr = we ? rd : 5'd0;
            x_wdata = we ? ext(f3, off, rdat) : 64'd0;
            tick();
        end
        req_valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0;
        rnd_mem();
        x_idle();
    endtask

    // reset asserted in the middle of RESP must clear outputs at once and never complete
    task automatic reset_mid();
        rnd_mem();
        req_valid_i = 1'b1; load_i = 1'b1; store_i = 1'b0; funct3_i = 3'b011; addr_i = 64'h1000; rd_i = 5'd7;
        x_idle(); x_stall = 1'b1;
        tick();
        rnd_req(); rnd_mem(); mem_req_ready_i = 1'b1;
        x_idle(); x_ready = 1'b0; x_stall = 1'b1; x_mreq = 1'b1; x_addr = 64'h1000;
        tick();
        rnd_req(); rnd_mem(); mem_resp_valid_i = 1'b0;
        x_idle(); x_ready = 1'b0; x_stall = 1'b1; x_rresp = 1'b1;
        #2;
        rst_n = 1'b1; req_valid_i = 1'b1; load_i = 1'b1; mem_resp_valid_i = 1'b1;
        x_idle();
        #1;
        check("rst_async_req_ready", req_ready_o, 1);
        check("rst_async_resp_ready", mem_resp_ready_o, 0);
        check("rst_async_stall", stall_o, 0);
        check("rst_async_done", done_o, 0);
        tick();
        rst_n = 1'b0; req_valid_i = 1'b0; load_i = 1'b0;
        rnd_mem();
        tick();
        tick();
    endtask

    initial begin
        int d0, rc0;
        logic l, s;
        logic [2:0] f;
        logic [63:0] a;
        rst_n = 1'b1; req_valid_i = 1'b1; load_i = 1'b1; store_i = 1'b0; funct3_i = '0; addr_i = '0;
        wdata_i = '0; rd_i = '0; mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_rdata_i = '0;
        mem_resp_err_i = 1'b0;
        x_idle();
        tick();
        tick();
        rst_n = 1'b0; req_valid_i = 1'b0; load_i = 1'b0;
        idle_gap(2);

        d0 = done_cnt;
        run_txn(1, 0, 3'b000, 64'h8000_0003, 64'd0, 5'd5, 0, 0, 64'h0000_0000_80FF_0000, 0);
        check("lb_wdata", d_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_waddr", d_waddr, 5);
        check("lb_we", d_we, 1);
        check("lb_req_to_done", d_cyc - r_cyc, 2);
        check("lb_done_once", done_cnt - d0, 1);

        d0 = done_cnt;
        run_txn(0, 1, 3'b001, 64'h8000_0006, 64'hABCD, 5'd9, 0, 0, 64'h1234, 0);
        check("sh_addr", r_addr, 64'h8000_0000);
        check("sh_strb", r_strb, 8'hC0);
        check("sh_wdata", r_wdata, 64'hABCD_0000_0000_0000);
        check("sh_wen", r_wen, 1);
        check("sh_reg_we", d_we, 0);
        check("sh_done_once", done_cnt - d0, 1);

        rc0 = req_cnt;
        run_txn(1, 0, 3'b010, 64'h8000_0002, 64'd0, 5'd3, 0, 0, 64'd0, 0);
        check("lw_mis_no_mem", req_cnt - rc0, 0);
        check("lw_mis_err", d_err, 1);
        check("lw_mis_we", d_we, 0);

        d0 = done_cnt;
        run_txn(1, 0, 3'b011, 64'h8000_0010, 64'd0, 5'd12, 3, 2, 64'h0123_4567_89AB_CDEF, 0);
        check("ld_wait_wdata", d_wdata, 64'h0123_4567_89AB_CDEF);
        check("ld_wait_done_once", done_cnt - d0, 1);

        d0 = done_cnt;
        reset_mid();
        check("rst_no_done", done_cnt - d0, 0);
        run_txn(1, 0, 3'b100, 64'h0, 64'd0, 5'd3, 0, 0, 64'h80, 0);
        check("lbu_after_rst", d_wdata, 64'h80);

        run_txn(1, 0, 3'b011, 64'h100, 64'd0, 5'd0, 0, 0, 64'hFFFF, 0);
        check("rd0_we", d_we, 0);
        check("rd0_err", d_err, 0);
        run_txn(1, 0, 3'b010, 64'h104, 64'd0, 5'd4, 1, 1, 64'hDEAD, 1);
        check("berr_we", d_we, 0);
        check("berr_err", d_err, 1);

        run_txn(1, 1, 3'b001, 64'h8000_0002, 64'hFFFF, 5'd6, 0, 0, 64'h0000_0000_8001_0000, 0);
        check("both_is_load_wen", r_wen, 0);
        check("both_is_load_wdata", d_wdata, 64'hFFFF_FFFF_FFFF_8001);

        for (int k = 0; k < 300; k++) begin
            l = 1'($urandom_range(0, 1));
            s = l ? 1'($urandom_range(0, 1)) : 1'b1;
            f = l ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~(3'((1 << f[1:0]) - 1));
            run_txn(l, s, f, a, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    {$urandom, $urandom}, 1'($urandom_range(0, 7) == 0));
            idle_gap(int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
